// File: rtl/axis_fifo_out_stage.sv
// -----------------------------------------------------------------------------
// axis_fifo_out_stage
//
// Turns a first-word-fall-through FIFO head into an AXI4-Stream master.
// A two-entry buffer sits between the FIFO and the stream:
//   - main register: drives m_axis_* directly, so tvalid comes from a register.
//   - skid register: catches the one word popped in the same cycle that
//     downstream stalls.
// The FIFO is popped from registered occupancy only. There is no combinational
// path from m_axis_tready to fifo_rd_en.
//
// Packet accounting: pkt_count counts accepted tlast beats and wraps at 2^32.
// busy is high while a packet is open.
//
// Optional feature, enabled by defining the macro AXIS_OUT_FORCE_LAST_EN:
//   A per-packet beat counter forces m_axis_tlast on beat MAX_BEATS.
//   Without the macro, the FIFO last flag passes through unchanged and no
//   beat counter exists.
// -----------------------------------------------------------------------------
module axis_fifo_out_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BEATS  = 1024
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic [DATA_WIDTH:0]   fifo_dout,
  input  logic                  fifo_valid,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [31:0]           pkt_count,
  output logic                  busy
);

  // Main register: the word currently presented downstream.
  logic                  r_main_valid;
  logic                  r_main_last;
  logic [DATA_WIDTH-1:0] r_main_data;

  // Skid register: only ever valid while main is valid.
  logic                  r_skid_valid;
  logic                  r_skid_last;
  logic [DATA_WIDTH-1:0] r_skid_data;

  // Packet accounting.
  logic [31:0]           r_pkt_count;
  logic                  r_busy;

  // Handshake decode.
  logic [1:0]            w_occupancy;
  logic                  w_pop;
  logic                  w_drain;
  logic [DATA_WIDTH-1:0] w_in_data;
  logic                  w_in_last;
  logic                  w_last_out;

  // Decode pop/drain from registered occupancy and the current inputs.
  always_comb begin
    // NOTE: every signal this block writes gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    w_occupancy = 2'd0;
    w_pop       = 1'b0;
    w_drain     = 1'b0;
    w_in_data   = '0;
    w_in_last   = 1'b0;

    w_occupancy = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
    // Reset gates the pop so no word leaves the FIFO while reset is held.
    w_pop       = fifo_valid && !reset && (w_occupancy != 2'd2);
    w_drain     = r_main_valid && m_axis_tready;
    w_in_data   = fifo_dout[DATA_WIDTH-1:0];
    w_in_last   = fifo_dout[DATA_WIDTH];
  end

  // Main register: load from skid on drain, otherwise from the FIFO when empty or draining.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // in this edge sees the pre-edge values of the others (skid -> main move).
    if (reset) begin
      // NOTE: the data and last registers are reset along with valid, because
      // m_axis_tdata and m_axis_tlast must read 0 straight after reset.
      r_main_valid <= 1'b0;
      r_main_last  <= 1'b0;
      r_main_data  <= '0;
    end else if (w_drain) begin
      if (r_skid_valid) begin
        r_main_last <= r_skid_last;
        r_main_data <= r_skid_data;
      end else if (w_pop) begin
        r_main_last <= w_in_last;
        r_main_data <= w_in_data;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_pop && !r_main_valid) begin
      r_main_valid <= 1'b1;
      r_main_last  <= w_in_last;
      r_main_data  <= w_in_data;
    end
  end

  // Skid register: capture a pop that lands while main is held, release it when main drains.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_skid_valid <= 1'b0;
      r_skid_last  <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_drain) begin
      // A pop cannot coincide with an occupied skid, because the buffer is then full.
      r_skid_valid <= 1'b0;
    end else if (w_pop && r_main_valid) begin
      r_skid_valid <= 1'b1;
      r_skid_last  <= w_in_last;
      r_skid_data  <= w_in_data;
    end
  end

`ifdef AXIS_OUT_FORCE_LAST_EN
  localparam int CNT_W = $clog2(MAX_BEATS);

  logic [CNT_W-1:0] r_beat_cnt;
  logic             w_force_last;

  // Beats already accepted in this packet. The presented beat is number
  // r_beat_cnt+1, so it is forced last when the count reaches MAX_BEATS-1.
  assign w_force_last = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign w_last_out   = r_main_last || w_force_last;

  // Count accepted beats per packet; any emitted tlast restarts the count.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_beat_cnt <= '0;
    end else if (w_drain) begin
      if (w_last_out) begin
        r_beat_cnt <= '0;
      end else begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
    end
  end
`else
  assign w_last_out = r_main_last;
`endif

  // Packet accounting: count accepted tlast beats and track whether a packet is open.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_pkt_count <= 32'd0;
      r_busy      <= 1'b0;
    end else if (w_drain) begin
      if (w_last_out) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
      r_busy <= !w_last_out;
    end
  end

  assign fifo_rd_en    = w_pop;
  assign m_axis_tvalid = r_main_valid;
  assign m_axis_tdata  = r_main_data;
  assign m_axis_tlast  = w_last_out;
  assign pkt_count     = r_pkt_count;
  assign busy          = r_busy;

  // The build parameters must stay inside their legal ranges.
  a_param_range: assert property (@(posedge aclk)
    (DATA_WIDTH >= 8) && (DATA_WIDTH <= 1024) && (MAX_BEATS >= 2) && (MAX_BEATS <= 65535));

  // The skid is filled only behind an occupied main register.
  a_skid_behind_main: assert property (@(posedge aclk) disable iff (reset)
    r_skid_valid |-> r_main_valid);

endmodule

// File: tb/tb_axis_fifo_out_stage.sv
// -----------------------------------------------------------------------------
// tb_axis_fifo_out_stage
// Directed self-checking bench for axis_fifo_out_stage. A queue models the FIFO,
// and a second queue collects the accepted stream beats. When the macro
// AXIS_OUT_FORCE_LAST_EN is defined, the DUT is built with MAX_BEATS=4 and the
// expected tlast positions include the forced beats.
// -----------------------------------------------------------------------------
module tb_axis_fifo_out_stage;

  localparam int DW = 64;
`ifdef AXIS_OUT_FORCE_LAST_EN
  localparam int MAXB  = 4;
  localparam bit FORCE = 1'b1;
`else
  localparam int MAXB  = 1024;
  localparam bit FORCE = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          reset;
  logic [DW:0]   fifo_dout;
  logic          fifo_valid;
  logic          fifo_rd_en;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [31:0]   pkt_count;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [DW:0] src_q[$];
  logic [DW:0] out_q[$];

  always #5 aclk = ~aclk;

  axis_fifo_out_stage #(
    .DATA_WIDTH(DW),
    .MAX_BEATS (MAXB)
  ) dut (
    .aclk         (aclk),
    .reset        (reset),
    .fifo_dout    (fifo_dout),
    .fifo_valid   (fifo_valid),
    .fifo_rd_en   (fifo_rd_en),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .pkt_count    (pkt_count),
    .busy         (busy)
  );

  // One clock cycle. The task starts at a falling edge and drives the FIFO head
  // from src_q, or junk when the FIFO is not offering a word. It samples the
  // handshakes 1 ns later, applies them at the rising edge, and returns at the
  // next falling edge.
  task automatic drive_cycle(input bit fv_en, input bit rdy,
                             output bit popped, output bit accepted, output logic [DW:0] beat);
    logic [DW:0] junk;
    junk          = {1'b1, 32'hDEAD_BEEF, 32'hBAD0_BAD0};
    fifo_valid    = fv_en && (src_q.size() > 0);
    fifo_dout     = fifo_valid ? src_q[0] : junk;
    m_axis_tready = rdy;
    #1;
    popped   = fifo_rd_en;
    accepted = m_axis_tvalid && rdy;
    beat     = {m_axis_tlast, m_axis_tdata};
    @(posedge aclk);
    if (popped && src_q.size() > 0) junk = src_q.pop_front();
    if (accepted) out_q.push_back(beat);
    @(negedge aclk);
  endtask

  task automatic do_reset;
    reset         = 1'b1;
    fifo_valid    = 1'b0;
    fifo_dout     = '0;
    m_axis_tready = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    reset = 1'b0;
    src_q.delete();
    out_q.delete();
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    fifo_valid    = 1'b1;
    fifo_dout     = {1'b1, 64'h1234_5678_9ABC_DEF0};
    m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 64'h0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL post_reset_rd_en: got %b want 1", fifo_rd_en); end
    fifo_valid = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL empty_rd_en: got %b want 0", fifo_rd_en); end
    @(negedge aclk);
  endtask

  // Words 1..8, last on 8, with tready high: one beat per cycle, starting one cycle after the first pop.
  task automatic test_stream;
    bit p, a;
    logic [DW:0] b;
    int n;
    bit exp_last;
    do_reset();
    for (int i = 1; i <= 8; i++) src_q.push_back({(i == 8), 64'(i)});
    n = 0;
    for (int c = 0; c < 14; c++) begin
      drive_cycle(1'b1, 1'b1, p, a, b);
      if (c == 0) begin
        checks++; if (p !== 1'b1) begin errors++; $display("FAIL stream_first_pop: got %b want 1", p); end
      end
      if (c == 3) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stream_busy_mid: got %b want 1", busy); end
      end
      if (a) begin
        n++;
        exp_last = (n == 8) || (FORCE && n == 4);
        checks++; if (b[DW-1:0] !== 64'(n)) begin errors++; $display("FAIL stream_data: beat %0d got %h want %h", n, b[DW-1:0], n); end
        checks++; if (b[DW] !== exp_last) begin errors++; $display("FAIL stream_last: beat %0d got %b want %b", n, b[DW], exp_last); end
        checks++; if (c != n) begin errors++; $display("FAIL stream_timing: beat %0d at cycle %0d want cycle %0d", n, c, n); end
      end
    end
    checks++; if (n != 8) begin errors++; $display("FAIL stream_count: got %0d beats want 8", n); end
    checks++; if (pkt_count !== (FORCE ? 32'd2 : 32'd1)) begin errors++; $display("FAIL stream_pkt_count: got %0d want %0d", pkt_count, FORCE ? 2 : 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_end: got %b want 0", busy); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL stream_tvalid_end: got %b want 0", m_axis_tvalid); end
  endtask

  // tready low: exactly two pops fill the buffer, then the head word is held until tready rises.
  task automatic test_backpressure;
    bit p, a;
    logic [DW:0] b;
    int pops;
    bit exp_last;
    do_reset();
    for (int i = 0; i < 5; i++) src_q.push_back({(i == 4), 64'h11 + 64'(i)});
    pops = 0;
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b1, 1'b0, p, a, b);
      pops += int'(p);
      if (c >= 2) begin
        checks++; if (p !== 1'b0) begin errors++; $display("FAIL bp_rd_en_full: cycle %0d got %b want 0", c, p); end
      end
      if (c >= 1) begin
        checks++; if (b[DW-1:0] !== 64'h11) begin errors++; $display("FAIL bp_tdata_stable: cycle %0d got %h want 11", c, b[DW-1:0]); end
      end
    end
    checks++; if (pops != 2) begin errors++; $display("FAIL bp_pop_count: got %0d want 2", pops); end
    checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid_held: got %b want 1", m_axis_tvalid); end
    for (int c = 0; c < 15 && out_q.size() < 5; c++) drive_cycle(1'b1, 1'b1, p, a, b);
    checks++; if (out_q.size() != 5) begin errors++; $display("FAIL bp_drain_count: got %0d want 5", out_q.size()); end
    for (int k = 0; k < out_q.size() && k < 5; k++) begin
      exp_last = (k == 4) || (FORCE && k == 3);
      checks++;
      if (out_q[k] !== {exp_last, 64'h11 + 64'(k)}) begin
        errors++; $display("FAIL bp_order: beat %0d got %h want %h", k, out_q[k], {exp_last, 64'h11 + 64'(k)});
      end
    end
    checks++; if (pkt_count !== (FORCE ? 32'd2 : 32'd1)) begin errors++; $display("FAIL bp_pkt_count: got %0d want %0d", pkt_count, FORCE ? 2 : 1); end
  endtask

  // 10000 words under 50% fifo_valid and 50% tready: the output must equal the input.
  task automatic test_random;
    localparam int N = 10000;
    logic [DW:0] exp_q[$];
    logic [DW:0] w;
    bit p, a, nat, el, exp_busy;
    logic [DW:0] b;
    int cnt, exp_pkts, mism, bad_pop;
    do_reset();
    cnt = 0; exp_pkts = 0; exp_busy = 1'b0;
    for (int i = 0; i < N; i++) begin
      nat = ($urandom_range(0, 7) == 0);
      w   = {nat, $urandom, $urandom};
      src_q.push_back(w);
      el  = nat || (FORCE && cnt == MAXB - 1);
      cnt = el ? 0 : cnt + 1;
      exp_pkts += int'(el);
      exp_busy = !el;
      exp_q.push_back({el, w[DW-1:0]});
    end
    bad_pop = 0;
    for (int c = 0; c < 60000 && out_q.size() < N; c++) begin
      drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), p, a, b);
      if (p && !fifo_valid) bad_pop++;
    end
    checks++; if (out_q.size() != N) begin errors++; $display("FAIL rand_count: got %0d beats want %0d (cycle budget)", out_q.size(), N); end
    mism = 0;
    for (int k = 0; k < out_q.size() && k < N; k++) begin
      if (out_q[k] !== exp_q[k]) begin
        if (mism < 5) $display("FAIL rand_word: beat %0d got %h want %h", k, out_q[k], exp_q[k]);
        mism++;
      end
    end
    checks++; if (mism != 0) begin errors++; $display("FAIL rand_order: got %0d mismatched beats want 0", mism); end
    checks++; if (bad_pop != 0) begin errors++; $display("FAIL rand_pop_without_valid: got %0d want 0", bad_pop); end
    checks++; if (pkt_count !== 32'(exp_pkts)) begin errors++; $display("FAIL rand_pkt_count: got %0d want %0d", pkt_count, exp_pkts); end
    checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy: got %b want %b", busy, exp_busy); end
  endtask

  // Reset asserted with the buffer full mid-packet: everything clears, and the buffered words are discarded.
  task automatic test_reset_mid;
    bit p, a;
    logic [DW:0] b;
    do_reset();
    for (int i = 0; i < 6; i++) src_q.push_back({1'b0, 64'h21 + 64'(i)});
    drive_cycle(1'b1, 1'b0, p, a, b);
    drive_cycle(1'b1, 1'b1, p, a, b);
    drive_cycle(1'b1, 1'b0, p, a, b);
    drive_cycle(1'b1, 1'b0, p, a, b);
    checks++; if (p !== 1'b0) begin errors++; $display("FAIL mid_full_rd_en: got %b want 0", p); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_open: got %b want 1", busy); end
    reset         = 1'b1;
    fifo_valid    = 1'b1;
    fifo_dout     = src_q[0];
    m_axis_tready = 1'b0;
    #1;
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_rst_rd_en: got %b want 0", fifo_rd_en); end
    @(posedge aclk);
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_rst_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL mid_rst_pkt_count: got %0d want 0", pkt_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL mid_rst_rd_en_held: got %b want 0", fifo_rd_en); end
    @(negedge aclk);
    reset = 1'b0;
    src_q.delete();
    out_q.delete();
    src_q.push_back({1'b1, 64'hA0});
    for (int c = 0; c < 6; c++) drive_cycle(1'b1, 1'b1, p, a, b);
    checks++; if (out_q.size() != 1) begin errors++; $display("FAIL mid_discard_count: got %0d beats want 1", out_q.size()); end
    if (out_q.size() > 0) begin
      checks++; if (out_q[0] !== {1'b1, 64'hA0}) begin errors++; $display("FAIL mid_discard_word: got %h want %h", out_q[0], {1'b1, 64'hA0}); end
    end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL mid_pkt_after: got %0d want 1", pkt_count); end
  endtask

  // pkt_count preset to 0xFFFFFFFF; one more last beat wraps it to 0.
  task automatic test_wrap;
    bit p, a;
    logic [DW:0] b;
    do_reset();
    force dut.r_pkt_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_pkt_count;
    #1;
    checks++; if (pkt_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset: got %h want ffffffff", pkt_count); end
    src_q.push_back({1'b1, 64'h77});
    for (int c = 0; c < 5 && out_q.size() < 1; c++) drive_cycle(1'b1, 1'b1, p, a, b);
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL wrap_to_zero: got %h want 0", pkt_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_busy: got %b want 0", busy); end
  endtask

`ifdef AXIS_OUT_FORCE_LAST_EN
  // MAX_BEATS=4 with a 10-word packet and no last flag: tlast is forced on beats 4 and 8.
  task automatic test_force_last;
    bit p, a, exp_last;
    logic [DW:0] b;
    do_reset();
    for (int i = 0; i < 10; i++) src_q.push_back({1'b0, 64'h31 + 64'(i)});
    for (int c = 0; c < 20 && out_q.size() < 10; c++) drive_cycle(1'b1, 1'b1, p, a, b);
    checks++; if (out_q.size() != 10) begin errors++; $display("FAIL force_count: got %0d want 10", out_q.size()); end
    for (int k = 0; k < out_q.size() && k < 10; k++) begin
      exp_last = (k == 3) || (k == 7);
      checks++;
      if (out_q[k] !== {exp_last, 64'h31 + 64'(k)}) begin
        errors++; $display("FAIL force_beat: beat %0d got %h want %h", k + 1, out_q[k], {exp_last, 64'h31 + 64'(k)});
      end
    end
    checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL force_pkt_count: got %0d want 2", pkt_count); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL force_busy: got %b want 1", busy); end
  endtask
`endif

  initial begin
    reset         = 1'b1;
    fifo_valid    = 1'b0;
    fifo_dout     = '0;
    m_axis_tready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_wrap();
`ifdef AXIS_OUT_FORCE_LAST_EN
    test_force_last();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
